// File: rtl/regfile_mp.sv
// Register file: one write port, two combinational read ports, optional hardwired x0, post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding in RUN.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] w_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                     state, state_nxt;
    logic [AW-1:0]              clr_idx, clr_idx_nxt;
    logic [NREG-1:0][XLEN-1:0]  regs;
    logic                       clr_we;
    logic                       wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // clr_idx wraps to 0 on the last entry since NREG is a power of two
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nxt = clr_idx + AW'(1);
            if (clr_idx == AW'(NREG - 1))
                state_nxt = RUN;
        end
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR);
        wr_ok  = (state == RUN) && w_en && ((ZERO_REG == 0) || (rd != '0));
    end

    // Array holds its contents through reset; the clear sequence defines it afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)
                regs[clr_idx] <= '0;
            else if (wr_ok)
                regs[rd] <= w_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] idx);
        logic [XLEN-1:0] val;
        if (busy || ((ZERO_REG != 0) && (idx == '0)))
            val = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wr_ok && (idx == rd))
            val = w_data;
`else
`endif
        else
            val = regs[idx];
        return val;
    endfunction

    always_comb begin
        rd_data1 = read_port(rs1);
        rd_data2 = read_port(rs2);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a 64-bit/16-entry/no-x0 instance; scoreboard queue of expectations.
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst, w_en, busy;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] w_data, rd_data1, rd_data2;

    // XLEN=64, NREG=16, ZERO_REG=0 instance
    logic        rst_b, w_en_b, busy_b;
    logic [3:0]  rd_b, rs1_b, rs2_b;
    logic [63:0] w_data_b, rd_data1_b, rd_data2_b;

    regfile_mp dut (
        .clk(clk), .rst(rst), .w_en(w_en), .rd(rd), .w_data(w_data),
        .rs1(rs1), .rs2(rs2), .rd_data1(rd_data1), .rd_data2(rd_data2), .busy(busy)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst_b), .w_en(w_en_b), .rd(rd_b), .w_data(w_data_b),
        .rs1(rs1_b), .rs2(rs2_b), .rd_data1(rd_data1_b), .rd_data2(rd_data2_b), .busy(busy_b)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic expect_val(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // advance one posedge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // count posedges until busy drops; -1 on timeout
    task automatic count_busy(input bit sel_b, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (!(sel_b ? busy_b : busy)) return;
        end
        n = -1;
    endtask

    initial begin
        int n;
        rst = 1'b1; w_en = 1'b0; rd = '0; w_data = '0; rs1 = 5'd31; rs2 = 5'd1;
        rst_b = 1'b1; w_en_b = 1'b0; rd_b = '0; w_data_b = '0; rs1_b = '0; rs2_b = '0;

        // 1: reset held 3 cycles, then clear lasts 32 cycles
        step(); step(); step();
        expect_val("reset_busy", 64'd1);      check({63'd0, busy});
        expect_val("reset_rd1", 64'd0);       check({32'd0, rd_data1});
        expect_val("reset_rd2", 64'd0);       check({32'd0, rd_data2});
        rst = 1'b0;
        expect_val("clear_len_32", 64'd32);
        count_busy(1'b0, n);
        check(64'(n));
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            expect_val($sformatf("cleared_rs1_%0d", i), 64'd0); check({32'd0, rd_data1});
            expect_val($sformatf("cleared_rs2_%0d", i), 64'd0); check({32'd0, rd_data2});
        end

        // 2: basic write/read and x0 hardwiring
        w_en = 1'b1; rd = 5'd5; w_data = 32'hDEADBEEF;
        step();
        w_en = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        expect_val("wr5_rd1", 64'hDEADBEEF); check({32'd0, rd_data1});
        expect_val("x0_rd2", 64'd0);         check({32'd0, rd_data2});
        w_en = 1'b1; rd = 5'd0; w_data = 32'h12345678;
        step();
        w_en = 1'b0; rs1 = 5'd0;
        #1;
        expect_val("x0_after_write", 64'd0); check({32'd0, rd_data1});

        // 3: same-cycle write and read of reg 7
        w_en = 1'b1; rd = 5'd7; w_data = 32'h11111111;
        step();
        w_data = 32'hA5A5A5A5; rs1 = 5'd7;
        #1;
        expect_val("same_cycle_rd7", BYP ? 64'hA5A5A5A5 : 64'h11111111); check({32'd0, rd_data1});
        step();
        w_en = 1'b0;
        #1;
        expect_val("next_cycle_rd7", 64'hA5A5A5A5); check({32'd0, rd_data1});

        // 4: writes during clear are dropped; reads stay 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        w_en = 1'b1; rd = 5'd31; w_data = 32'hFFFFFFFF; rs1 = 5'd31; rs2 = 5'd7;
        #1;
        expect_val("clr10_rd1", 64'd0); check({32'd0, rd_data1});
        expect_val("clr10_rd2", 64'd0); check({32'd0, rd_data2});
        step();
        rd = 5'd3; w_data = 32'hCAFEF00D;   // index 3 is already cleared
        step();
        w_en = 1'b0;
        n = 12;
        while (busy && n < 200) begin
            expect_val("clr_rd1_zero", 64'd0); check({32'd0, rd_data1});
            expect_val("clr_rd2_zero", 64'd0); check({32'd0, rd_data2});
            step();
            n++;
        end
        expect_val("clear_len_from_reset", 64'd32); check(64'(n));
        rs1 = 5'd31; rs2 = 5'd3;
        #1;
        expect_val("reg31_dropped", 64'd0); check({32'd0, rd_data1});
        expect_val("reg3_dropped", 64'd0);  check({32'd0, rd_data2});

        // 5: reset from RUN clears regs 1..3; reset mid-clear restarts
        for (int i = 1; i <= 3; i++) begin
            w_en = 1'b1; rd = 5'(i); w_data = 32'h100 * i + 32'h1;
            step();
        end
        w_en = 1'b0; rs1 = 5'd2; rs2 = 5'd3;
        #1;
        expect_val("pre_rst_r2", 64'h201); check({32'd0, rd_data1});
        expect_val("pre_rst_r3", 64'h301); check({32'd0, rd_data2});
        rst = 1'b1; w_en = 1'b1; rd = 5'd1; w_data = 32'hBAD0BAD0;
        step();
        rst = 1'b0; w_en = 1'b0;
        expect_val("busy_after_run_rst", 64'd1); check({63'd0, busy});
        expect_val("clear_len_run_rst", 64'd32);
        count_busy(1'b0, n);
        check(64'(n));
        for (int i = 1; i <= 3; i++) begin
            rs1 = 5'(i);
            #1;
            expect_val($sformatf("post_rst_r%0d", i), 64'd0); check({32'd0, rd_data1});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_val("clear_len_restart", 64'd32);
        count_busy(1'b0, n);
        check(64'(n));

        // 6: 64-bit, 16 entries, index 0 ordinary
        step();
        rst_b = 1'b0;
        expect_val("b_clear_len_16", 64'd16);
        count_busy(1'b1, n);
        check(64'(n));
        w_en_b = 1'b1; rd_b = 4'd0; w_data_b = 64'h0123456789ABCDEF;
        step();
        w_en_b = 1'b1; rd_b = 4'd15; w_data_b = 64'hFEDCBA9876543210; rs1_b = 4'd0;
        #1;
        expect_val("b_r0", 64'h0123456789ABCDEF); check(rd_data1_b);
        step();
        w_en_b = 1'b0; rs2_b = 4'd15;
        #1;
        expect_val("b_r15", 64'hFEDCBA9876543210); check(rd_data2_b);
        expect_val("b_busy_low", 64'd0); check({63'd0, busy_b});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
